trackball_counter: RTL
======================

# trackball_counter

Receiving end of the trackball step interface: consumes the per-axis `dir`/`clk` step signals produced by the trackball emulator (or a real trackball front end) and accumulates them into up/down position counters that the game CPU reads. Inputs are treated as asynchronous; each axis is synchronized, glitch-filtered and edge-detected, and every qualified toggle of an axis clock counts as one step. It sits between the trackball emulator outputs and the CPU I/O decode.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per input, minimum 2.
- `FILTER_LEN`, 4: consecutive cycles a synchronized axis clock level must hold before it is accepted, range 1..255.
- `CNT_WIDTH`, 8: position counter width.
- `CLEAR_ON_READ`, 0: 1 = the read counter is zeroed by the read strobe.
- `clk  in  1  system clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `flip  in  1  1 = invert count direction on both axes`
- `h_clk  in  1  horizontal step clock; each toggle is one step`
- `h_dir  in  1  horizontal direction; 0 = increment, 1 = decrement`
- `v_clk  in  1  vertical step clock`
- `v_dir  in  1  vertical direction; 0 = increment, 1 = decrement`
- `cpu_rd  in  1  one-cycle read strobe`
- `cpu_sel  in  1  0 = horizontal counter, 1 = vertical counter`
- `cpu_clr  in  1  synchronous clear of both counters`
- `cpu_dout  out  CNT_WIDTH  registered read data`
- `rd_valid  out  1  pulses 1 cycle after cpu_rd; cpu_dout is valid while it is high and holds until the next read`
- `h_step  out  1  1-cycle pulse per counted horizontal step`
- `v_step  out  1  1-cycle pulse per counted vertical step`

## Operation
- Each axis is independent and identical. `clk` and `dir` each pass through `SYNC_STAGES` flops.
- Filter: an 8-bit stability counter tracks the synchronized clock. It resets to 1 when the synchronized level changes and increments, saturating, while the level holds. When it reaches `FILTER_LEN`, the level is "qualified".
- Arming: `armed` resets to 0. The first qualification after reset loads `filt`, sets `armed` and does not count. This stops an input that is high at reset release from producing a spurious step.
- When armed and the qualified level differs from `filt`, `filt` is updated and a step is raised for the next cycle.
- Step direction is `sync_dir XOR flip`, sampled in the cycle `filt` changes. 0 adds 1 and 1 subtracts 1, modulo 2^CNT_WIDTH. There is no saturation, and the counter wraps 255↔0.
- Read: on `cpu_rd`, `cpu_dout` loads the selected counter's value from before any same-cycle step, and `rd_valid` pulses.
- With `CLEAR_ON_READ`=1, the selected counter becomes 0, plus or minus 1 if a step lands in the same cycle. Steps are never lost.
- `cpu_clr` zeroes both counters, and a same-cycle step is discarded. If `cpu_clr` and `cpu_rd` coincide, the read returns the pre-clear value.
- Reset values:
  - Counters, `filt`, `armed` and all synchronizer flops: 0.
  - Stability counters: 0.
  - `cpu_dout`, `rd_valid`, `h_step`, `v_step`: 0.
- Asserting `reset_n` mid-operation aborts everything, including a pending step. After release the arming sequence repeats.

## Timing
- Latency: a raw axis clock toggle first sampled at edge 0 sets `filt` at edge `SYNC_STAGES+FILTER_LEN-1`. The counter and `h_step`/`v_step` update at edge `SYNC_STAGES+FILTER_LEN`, which is edge 6 with the defaults.
- Pulses shorter than `FILTER_LEN` cycles after synchronization are ignored entirely.
- Maximum count rate is one step per `FILTER_LEN` cycles per axis. The emulator's minimum half-period of ~3000 cycles is far above this.
- `dir` must be stable from at least `SYNC_STAGES` cycles before the clock toggle until the step.
- Read latency is 1 cycle. Back-to-back `cpu_rd` is allowed on every cycle.

## Test plan
- Reset with `h_clk`=1, release, hold 20 cycles -> no `h_step`, H count 0. Then drop `h_clk` -> exactly one step at edge 6, H count = 1.
- `v_dir`=0, `flip`=0, 10 `v_clk` toggles at 100-cycle spacing -> V count = 10. With `flip`=1 and 10 more toggles -> V count = 0.
- Glitches of 1..3 cycles on `h_clk` (`FILTER_LEN`=4) -> no steps. A 4-cycle hold -> one step.
- H count at 255, one increment -> 0. Then `h_dir`=1, one step -> 255.
- `CLEAR_ON_READ`=1, H count 7, `cpu_rd`/`cpu_sel`=0 coincident with a +1 step -> `cpu_dout`=7 with `rd_valid` one cycle later, H count = 1.
- `cpu_clr` coincident with a V step -> V count 0 and `v_step` still pulses. `reset_n` asserted during a filter window -> all outputs 0 and no step after release.

Source files
------------

// File: rtl/trackball_counter.sv
// Trackball step receiver: per-axis synchronizer, glitch filter and edge detector
// feeding wrapping up/down position counters with a registered CPU read port.

module trackball_axis #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flip,
    input  logic                 raw_clk,
    input  logic                 raw_dir,
    input  logic                 clr,
    input  logic                 rd_clr,
    output logic                 step,
    output logic [CNT_WIDTH-1:0] cnt
);
    localparam int unsigned          STAB_W   = 8;
    localparam logic [STAB_W-1:0]    STAB_ONE = STAB_W'(1);
    localparam logic [STAB_W-1:0]    STAB_MAX = '1;
    localparam logic [STAB_W-1:0]    QUAL_LEN = STAB_W'(FILTER_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic                   level;
    logic                   last_level;
    logic [STAB_W-1:0]      stab;
    logic [STAB_W-1:0]      stab_next;
    logic                   qualified;
    logic                   toggle;
    logic                   filt;
    logic                   armed;
    logic                   pend;
    logic                   pend_dir;
    logic [CNT_WIDTH-1:0]   cnt_base;
    logic [CNT_WIDTH-1:0]   cnt_next;

    assign level = clk_sync[SYNC_STAGES-1];

    // Stability tracking: restart at 1 on a level change, otherwise count up and saturate.
    always_comb begin
        stab_next = stab;
        if (level != last_level) begin
            stab_next = STAB_ONE;
        end else if (stab != STAB_MAX) begin
            stab_next = stab + STAB_ONE;
        end
        qualified = (stab_next == QUAL_LEN);
        toggle    = qualified && armed && (level != filt);
    end

    // Counter next value: read-clear and steps combine, a clear wins over everything.
    always_comb begin
        cnt_base = rd_clr ? '0 : cnt;
        cnt_next = cnt_base;
        if (pend) begin
            cnt_next = pend_dir ? (cnt_base - CNT_ONE) : (cnt_base + CNT_ONE);
        end
        if (clr) begin
            cnt_next = '0;
        end
    end

    // Synchronizers, filter, arming, step pipeline and position counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= '0;
            dir_sync   <= '0;
            last_level <= 1'b0;
            stab       <= '0;
            filt       <= 1'b0;
            armed      <= 1'b0;
            pend       <= 1'b0;
            pend_dir   <= 1'b0;
            step       <= 1'b0;
            cnt        <= '0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], raw_clk};
            dir_sync   <= {dir_sync[SYNC_STAGES-2:0], raw_dir};
            last_level <= level;
            stab       <= stab_next;
            if (qualified && !armed) begin
                // First accepted level after reset only establishes the baseline.
                filt  <= level;
                armed <= 1'b1;
            end else if (toggle) begin
                filt <= level;
            end
            pend <= toggle;
            if (toggle) begin
                pend_dir <= dir_sync[SYNC_STAGES-1] ^ flip;
            end
            step <= pend;
            cnt  <= cnt_next;
        end
    end
endmodule

module trackball_counter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_LEN    = 4,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter int unsigned CLEAR_ON_READ = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flip,
    input  logic                 h_clk,
    input  logic                 h_dir,
    input  logic                 v_clk,
    input  logic                 v_dir,
    input  logic                 cpu_rd,
    input  logic                 cpu_sel,
    input  logic                 cpu_clr,
    output logic [CNT_WIDTH-1:0] cpu_dout,
    output logic                 rd_valid,
    output logic                 h_step,
    output logic                 v_step
);
    localparam logic CLR_RD = (CLEAR_ON_READ != 0);

    logic [CNT_WIDTH-1:0] h_cnt;
    logic [CNT_WIDTH-1:0] v_cnt;
    logic                 h_rd_clr;
    logic                 v_rd_clr;

    assign h_rd_clr = CLR_RD && cpu_rd && !cpu_sel;
    assign v_rd_clr = CLR_RD && cpu_rd && cpu_sel;

    trackball_axis #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .flip    (flip),
        .raw_clk (h_clk),
        .raw_dir (h_dir),
        .clr     (cpu_clr),
        .rd_clr  (h_rd_clr),
        .step    (h_step),
        .cnt     (h_cnt)
    );

    trackball_axis #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .flip    (flip),
        .raw_clk (v_clk),
        .raw_dir (v_dir),
        .clr     (cpu_clr),
        .rd_clr  (v_rd_clr),
        .step    (v_step),
        .cnt     (v_cnt)
    );

    // Read port: capture the pre-update counter value and flag it one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_dout <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= cpu_rd;
            if (cpu_rd) begin
                cpu_dout <= cpu_sel ? v_cnt : h_cnt;
            end
        end
    end
endmodule
